// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and enums for the register-file write-back path.
//   REG_W      : register data width
//   REG_COUNT  : number of architectural registers (power of two, >= 4)
//   REG_IDX_W  : register index width
//   wb_state_e : write-back controller state (clearing sweep, then run)
//   src_e      : write producer identity (A = ALU result, B = load result)
package brisc_pkg;

  localparam int REG_W     = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_IDX_W = $clog2(REG_COUNT);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } wb_state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the two producer handshakes plus the register-file write port.
//   a_valid/a_ready/a_reg/a_data : producer A (ALU) write request
//   b_valid/b_ready/b_reg/b_data : producer B (load) write request
//   wr_en/wr_reg/wr_data         : registered register-file write port
//   init_done                    : clearing sweep finished
// Modports:
//   slave  : the write-back controller (consumes requests, drives write port)
//   master : the surrounding pipeline / register file side
interface regfile_wb_arbiter_if;
  import brisc_pkg::*;

  logic                 a_valid;
  logic                 a_ready;
  logic [REG_IDX_W-1:0] a_reg;
  logic [REG_W-1:0]     a_data;

  logic                 b_valid;
  logic                 b_ready;
  logic [REG_IDX_W-1:0] b_reg;
  logic [REG_W-1:0]     b_data;

  logic                 wr_en;
  logic [REG_IDX_W-1:0] wr_reg;
  logic [REG_W-1:0]     wr_data;
  logic                 init_done;

  modport slave (
    input  a_valid, a_reg, a_data,
    input  b_valid, b_reg, b_data,
    output a_ready, b_ready,
    output wr_en, wr_reg, wr_data, init_done
  );

  modport master (
    output a_valid, a_reg, a_data,
    output b_valid, b_reg, b_data,
    input  a_ready, b_ready,
    input  wr_en, wr_reg, wr_data, init_done
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter_2.sv
// Two-requester round-robin arbiter.
//   clk, reset : clock and synchronous active-high reset
//   en         : arbitration allowed this cycle (no grant when low)
//   valid[1:0] : requests, bit 0 = A, bit 1 = B
//   grant[1:0] : one-hot grant, purely combinational from valid/en/last grant
// The last-grant flop resets to B so that A wins the first tie.
module rr_arbiter_2
  import brisc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  src_e last_grant_q;
  src_e last_grant_d;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // Tie: whichever source did not win last time.
        2'b11:   grant = (last_grant_q == SRC_B) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // A grant is an acceptance because grant is only raised on a valid request.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant[0]) begin
      last_grant_d = SRC_A;
    end else if (grant[1]) begin
      last_grant_d = SRC_B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= SRC_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller owning the register file's single write port.
// After every reset it sweeps zeros into registers 1..REG_COUNT-1, then
// shares the port round-robin between producer A (ALU) and producer B (load).
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : regfile_wb_arbiter_if.slave (producer handshakes, write port,
//           init_done)
// Accept on edge N -> write presented in cycle N+1. Writes to register 0 are
// accepted but never issued.
module regfile_wb_arbiter
  import brisc_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_arbiter_if.slave   bus
);

  wb_state_e            state_q,     state_d;
  logic [REG_IDX_W-1:0] clr_idx_q,   clr_idx_d;
  logic                 wr_en_q,     wr_en_d;
  logic [REG_IDX_W-1:0] wr_reg_q,    wr_reg_d;
  logic [REG_W-1:0]     wr_data_q,   wr_data_d;
  logic                 init_done_q, init_done_d;

  logic [1:0]           grant;
  logic                 arb_en;
  logic [REG_IDX_W-1:0] sel_reg;
  logic [REG_W-1:0]     sel_data;

  // Readys stay low while reset is asserted so nothing is handed off in a
  // cycle whose result would be thrown away.
  assign arb_en = (state_q == RUN) && !reset;

  rr_arbiter_2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .valid ({bus.b_valid, bus.a_valid}),
    .grant (grant)
  );

  assign bus.a_ready = grant[0];
  assign bus.b_ready = grant[1];

  assign sel_reg  = grant[1] ? bus.b_reg  : bus.a_reg;
  assign sel_data = grant[1] ? bus.b_data : bus.a_data;

  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    wr_en_d     = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    init_done_d = init_done_q;

    case (state_q)
      INIT: begin
        wr_en_d   = 1'b1;
        wr_reg_d  = clr_idx_q;
        wr_data_d = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == REG_IDX_W'(REG_COUNT - 1)) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        // Register 0 is hardwired: consume the request but issue nothing.
        if ((|grant) && (sel_reg != '0)) begin
          wr_en_d   = 1'b1;
          wr_reg_d  = sel_reg;
          wr_data_d = sel_data;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      clr_idx_q   <= REG_IDX_W'(1);
      wr_en_q     <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      wr_en_q     <= wr_en_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_reg    = wr_reg_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized producer traffic, checked against a behavioural model of the
// write-back rules and a register-file image.
module tb_regfile_wb_arbiter;
  import brisc_pkg::*;

  logic clk;
  logic rst_v;
  logic rf_clear;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .reset (rst_v),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file as seen downstream of the write port.
  logic [REG_W-1:0] rf [REG_COUNT];
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int k = 0; k < REG_COUNT; k++) rf[k] <= (k == 0) ? '0 : (32'hBAD0_0000 | k);
    end else if (bus.wr_en) begin
      rf[bus.wr_reg] <= bus.wr_data;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Producer request state: a request stays valid until accepted.
  logic                 a_pend, b_pend;
  logic [REG_IDX_W-1:0] a_r, b_r;
  logic [REG_W-1:0]     a_d, b_d;

  // Behavioural model.
  logic                 m_run;      // sweep finished
  int                   m_idx;      // next register the sweep clears
  logic                 m_last_b;   // most recent winner was B
  logic                 e_en, e_done;
  logic [REG_IDX_W-1:0] e_reg;
  logic [REG_W-1:0]     e_data;
  logic [REG_W-1:0]     m_rf [REG_COUNT];

  // One clock: drive requests, check readys, advance the model, check outputs.
  task automatic cycle();
    logic ga, gb;
    bus.a_valid = a_pend;
    bus.a_reg   = a_r;
    bus.a_data  = a_d;
    bus.b_valid = b_pend;
    bus.b_reg   = b_r;
    bus.b_data  = b_d;
    #1;
    ga = 1'b0;
    gb = 1'b0;
    if (!rst_v && m_run) begin
      if (a_pend && b_pend) begin
        ga = m_last_b;
        gb = !m_last_b;
      end else begin
        ga = a_pend;
        gb = b_pend;
      end
    end
    chk("a_ready", bus.a_ready, ga);
    chk("b_ready", bus.b_ready, gb);

    if (rst_v) begin
      e_en = 0; e_reg = '0; e_data = '0; e_done = 0;
      m_run = 0; m_idx = 1; m_last_b = 1;
    end else if (!m_run) begin
      e_en   = 1;
      e_reg  = REG_IDX_W'(m_idx);
      e_data = '0;
      m_rf[m_idx] = '0;
      if (m_idx == REG_COUNT - 1) begin
        m_run  = 1;
        e_done = 1;
      end
      m_idx++;
    end else begin
      e_en = 0;
      if (ga || gb) begin
        logic [REG_IDX_W-1:0] r;
        logic [REG_W-1:0]     d;
        r = ga ? a_r : b_r;
        d = ga ? a_d : b_d;
        m_last_b = gb;
        if (r != 0) begin
          e_en   = 1;
          e_reg  = r;
          e_data = d;
          m_rf[r] = d;
        end
        if (ga) a_pend = 0;
        else    b_pend = 0;
      end
    end

    @(posedge clk);
    @(negedge clk);
    chk("wr_en",     bus.wr_en,     e_en);
    chk("wr_reg",    bus.wr_reg,    e_reg);
    chk("wr_data",   bus.wr_data,   e_data);
    chk("init_done", bus.init_done, e_done);
  endtask

  task automatic rand_reqs();
    if (!a_pend && ($urandom_range(0, 1) == 1)) begin
      a_pend = 1;
      a_r    = REG_IDX_W'($urandom_range(0, REG_COUNT - 1));
      a_d    = $urandom;
    end
    if (!b_pend && ($urandom_range(0, 1) == 1)) begin
      b_pend = 1;
      b_r    = REG_IDX_W'($urandom_range(0, REG_COUNT - 1));
      b_d    = $urandom;
    end
  endtask

  logic [REG_IDX_W-1:0] seq [4];

  initial begin
    rf_clear = 1;
    rst_v    = 1;
    a_pend = 0; b_pend = 0;
    a_r = '0; b_r = '0; a_d = '0; b_d = '0;
    m_run = 0; m_idx = 1; m_last_b = 1;
    e_en = 0; e_reg = '0; e_data = '0; e_done = 0;
    for (int k = 0; k < REG_COUNT; k++) m_rf[k] = (k == 0) ? '0 : (32'hBAD0_0000 | k);

    // Reset, then a full sweep with no requests.
    cycle();
    rf_clear = 0;
    cycle();
    rst_v = 0;
    repeat (REG_COUNT - 1) cycle();
    cycle();
    chk("init_done_after_sweep", bus.init_done, 1'b1);
    chk("sweep_r31", rf[REG_COUNT-1], 32'h0);

    // Single A write to r5.
    a_pend = 1; a_r = 5; a_d = 32'hDEAD_BEEF;
    cycle();
    chk("a5_wr_reg", bus.wr_reg, 5);
    cycle();
    chk("r5_read", rf[5], 32'hDEAD_BEEF);

    // Make B the most recent winner so the tie run starts with A.
    b_pend = 1; b_r = 6; b_d = 32'h66;
    cycle();

    // Both producers continuously valid for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      a_pend = 1; a_r = 3; a_d = 32'h11;
      b_pend = 1; b_r = 4; b_d = 32'h22;
      cycle();
      seq[i] = bus.wr_reg;
    end
    a_pend = 0; b_pend = 0;
    for (int i = 0; i < 4; i++) chk("tie_seq", seq[i], (i % 2 == 0) ? 3 : 4);

    // Write to register 0 is swallowed.
    b_pend = 1; b_r = 0; b_d = 32'hFFFF_FFFF;
    cycle();
    chk("r0_wr_en", bus.wr_en, 1'b0);
    cycle();
    chk("r0_read", rf[0], 32'h0);

    // Both target r7 with B as last winner: A lands first, then B.
    a_pend = 1; a_r = 7; a_d = 32'hAAAA;
    b_pend = 1; b_r = 7; b_d = 32'hBBBB;
    cycle();
    chk("r7_first", bus.wr_data, 32'hAAAA);
    cycle();
    chk("r7_second", bus.wr_data, 32'hBBBB);
    cycle();
    chk("r7_read", rf[7], 32'hBBBB);

    // Random traffic.
    repeat (300) begin
      rand_reqs();
      cycle();
    end

    // Reset in the middle of a sweep, at index 10.
    rst_v = 1;
    cycle();
    rst_v = 0;
    repeat (10) cycle();
    chk("sweep_idx10", bus.wr_reg, 10);
    rst_v = 1;
    rand_reqs();
    cycle();
    chk("midreset_wr_en", bus.wr_en, 1'b0);
    rst_v = 0;
    // Requests held through the restarted sweep must not be taken early.
    repeat (REG_COUNT - 1) begin
      rand_reqs();
      cycle();
    end
    repeat (200) begin
      rand_reqs();
      cycle();
    end

    // Drain and compare the whole register file image.
    a_pend = 0; b_pend = 0;
    repeat (2) cycle();
    for (int k = 0; k < REG_COUNT; k++) chk("rf_image", rf[k], m_rf[k]);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back controller for the core's register file: owns the file's single write port (`wr_en`/`wr_reg`/`wr_data`) and shares it between two producers, A (ALU result) and B (load result).
- After every reset it runs a clearing sweep that writes zero to registers 1..REG_COUNT-1.
- It then arbitrates producer writes round-robin over valid/ready handshakes and drives one registered write per cycle.
- It sits between the execute/memory stages and `register_file`.

## Interface
- REG_W, 32, register data width
- REG_COUNT, 32, number of architectural registers (power of two, ≥4)
- REG_IDX_W, $clog2(REG_COUNT), register index width
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- a_valid  in  1  producer A has a write pending
- a_ready  out  1  A's write accepted this cycle when a_valid && a_ready
- a_reg  in  REG_IDX_W  A destination register
- a_data  in  REG_W  A write data
- b_valid, b_ready, b_reg, b_data  same as A, for producer B
- wr_en  out  1  register_file write enable (registered)
- wr_reg  out  REG_IDX_W  register_file write index (registered)
- wr_data  out  REG_W  register_file write data (registered)
- init_done  out  1  high once the clearing sweep has finished (registered)

## Operation
- FSM states:
  - INIT: entered on reset.
    - Counter `clr_idx` starts at 1.
    - Each cycle: wr_en=1, wr_reg=clr_idx, wr_data=0, clr_idx++.
    - After issuing index REG_COUNT-1, go to RUN.
  - RUN: terminal state until reset.
- In INIT, a_ready=b_ready=0; producer valids are ignored and must be held by the producers.
- In RUN, arbitration is combinational on the valids:
  - Only A valid → a_ready=1.
  - Only B valid → b_ready=1.
  - Both valid → grant the source not granted last; ties go by the `last_grant` flop.
  - Never both readys high in the same cycle.
- On acceptance:
  - `last_grant` ← granted source.
  - Next cycle: wr_en=1, wr_reg=granted reg, wr_data=granted data.
- No acceptance in a cycle → next cycle wr_en=0; wr_reg/wr_data hold their previous values.
- Destination register 0: the write is accepted (ready=1, `last_grant` updates) but the next-cycle wr_en=0. Register 0 is never written, including during the sweep.
- Both producers targeting the same register: writes are serialized in grant order, so the later grant's data lands last. No merging.
- Reset values:
  - wr_en=0, wr_reg=0, wr_data=0, init_done=0, a_ready=b_ready=0.
  - `last_grant`=B, so A wins the first tie.
  - state=INIT, clr_idx=1.
- Reset asserted mid-sweep or mid-RUN: all of the above values restored at that edge and the sweep restarts at index 1. An accepted but not-yet-issued write is discarded.

## Timing
- Sweep:
  - Reset deasserted before edge E0 → wr_en high for cycles E0..E0+REG_COUNT-2, with wr_reg 1..REG_COUNT-1 in order.
  - init_done rises and RUN is entered after edge E0+REG_COUNT-2, i.e. REG_COUNT-1 cycles after reset release.
- Handshake latency: accept on edge N → wr_en/wr_reg/wr_data valid in cycle N+1. register_file captures at edge N+1, so data is readable from cycle N+2.
- Throughput: one write per cycle; back-to-back grants allowed.
- Both producers continuously valid → grants alternate A,B,A,B…
- The ready outputs depend combinationally on the valids and registered state only; there is no combinational path from data inputs.

## Structure
- Shared package `brisc_pkg`: REG_W, REG_COUNT, REG_IDX_W constants; state enum {INIT, RUN}; source enum {SRC_A, SRC_B}.
- Sub-module `rr_arbiter_2`:
  - Inputs: valid[1:0], registered last-grant.
  - Outputs: one-hot grant.
  - Purely combinational plus the last-grant flop.
- Top level holds the FSM, sweep counter, and output registers.

## Test plan
- Reset release, no valids → wr_en high 31 cycles, wr_reg 1..31, wr_data 0; init_done=1 afterwards; readys 0 throughout the sweep.
- RUN, a_valid with a_reg=5, a_data=0xDEADBEEF for one cycle → a_ready=1; next cycle wr_en=1, wr_reg=5, wr_data=0xDEADBEEF; a register_file read of r5 returns 0xDEADBEEF.
- Both valid for 4 cycles (A: r3, 0x11; B: r4, 0x22) → grant order A,B,A,B; wr_reg sequence 3,4,3,4.
- b_valid with b_reg=0, b_data=0xFFFFFFFF → b_ready=1; next cycle wr_en=0; r0 reads 0.
- Reset asserted at sweep index 10 → outputs 0 next edge; after release the sweep restarts at wr_reg=1 and runs 31 cycles.
- A and B both target r7 (A 0xAAAA, B 0xBBBB), last_grant=B → A written first, then B; r7 finally reads 0xBBBB.
